// File: rtl/pa_wb_arbiter_if.sv
// pa_wb_arbiter_if: writeback-side bus of the PA_Core writeback arbiter.
// master = core / source side (drives both writeback requests),
// slave  = arbiter side (drives B ready, the register-file port and FIFO occupancy).
interface pa_wb_arbiter_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int B_DEPTH = 4
);
    localparam int CNT_W = $clog2(B_DEPTH) + 1;

    logic              wbA_i;
    logic [ADDR_W-1:0] wbAddrA_i;
    logic [DATA_W-1:0] wbValA_i;
    logic              wbB_i;
    logic [ADDR_W-1:0] wbAddrB_i;
    logic [DATA_W-1:0] wbValB_i;
    logic              wbBReady_o;
    logic              regWrEn_o;
    logic [ADDR_W-1:0] regWrAddr_o;
    logic [DATA_W-1:0] regWrVal_o;
    logic [CNT_W-1:0]  bCount_o;

    modport master (
        output wbA_i, wbAddrA_i, wbValA_i, wbB_i, wbAddrB_i, wbValB_i,
        input  wbBReady_o, regWrEn_o, regWrAddr_o, regWrVal_o, bCount_o
    );

    modport slave (
        input  wbA_i, wbAddrA_i, wbValA_i, wbB_i, wbAddrB_i, wbValB_i,
        output wbBReady_o, regWrEn_o, regWrAddr_o, regWrVal_o, bCount_o
    );
endinterface

// File: rtl/pa_wb_arbiter.sv
// pa_wb_arbiter: merges the arithmetic (A, fixed priority) and load (B, valid/ready)
// writeback sources into one registered register-file write port. B writes that
// collide with A wait in an in-order FIFO; a younger A write invalidates queued B
// entries to the same register so per-register write order follows program order.
// Optional feature: define PA_WB_BYPASS_EN to let an accepted B skip the empty FIFO
// when A is idle (1-cycle B latency instead of 2).
module pa_wb_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int B_DEPTH = 4
) (
    input  logic            clock_i,
    input  logic            reset_i,
    pa_wb_arbiter_if.slave  wb
);
    localparam int PTR_W = $clog2(B_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fifoAddr_q [B_DEPTH];
    logic [DATA_W-1:0] fifoVal_q  [B_DEPTH];
    logic [B_DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wrEn_q, wrEn_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [DATA_W-1:0] wrVal_q, wrVal_d;

    logic ready;
    logic bypass;
    logic push;
    logic pop;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign ready = (count_q != CNT_W'(B_DEPTH));

`ifdef PA_WB_BYPASS_EN
    assign bypass = wb.wbB_i & ready & ~wb.wbA_i & (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    // An entry enqueued this cycle is not visible to pop until the next cycle (count_q still 0).
    assign push = wb.wbB_i & ready & ~bypass;
    assign pop  = ~wb.wbA_i & (count_q != '0);

    // FIFO bookkeeping: squash by A, pop head, append new B entry (never squashed by the same-cycle A).
    always_comb begin
        vld_d   = vld_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (wb.wbA_i) begin
            for (int i = 0; i < B_DEPTH; i++) begin
                if (fifoAddr_q[i] == wb.wbAddrA_i) vld_d[i] = 1'b0;
            end
        end
        if (pop) begin
            vld_d[rdPtr_q] = 1'b0;
            rdPtr_d        = rdPtr_q + PTR_W'(1);
        end
        if (push) begin
            vld_d[wrPtr_q] = 1'b1;
            wrPtr_d        = wrPtr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Write-port selection: A always wins, then the FIFO head, then (optionally) bypassed B.
    always_comb begin
        wrEn_d   = 1'b0;
        wrAddr_d = wrAddr_q;
        wrVal_d  = wrVal_q;
        if (wb.wbA_i) begin
            wrEn_d   = 1'b1;
            wrAddr_d = wb.wbAddrA_i;
            wrVal_d  = wb.wbValA_i;
        end else if (pop) begin
            if (vld_q[rdPtr_q]) begin
                wrEn_d   = 1'b1;
                wrAddr_d = fifoAddr_q[rdPtr_q];
                wrVal_d  = fifoVal_q[rdPtr_q];
            end
        end else if (bypass) begin
            wrEn_d   = 1'b1;
            wrAddr_d = wb.wbAddrB_i;
            wrVal_d  = wb.wbValB_i;
        end
    end

    // Control and output registers; reset discards every in-flight entry.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            vld_q    <= '0;
            rdPtr_q  <= '0;
            wrPtr_q  <= '0;
            count_q  <= '0;
            wrEn_q   <= 1'b0;
            wrAddr_q <= '0;
            wrVal_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            rdPtr_q  <= rdPtr_d;
            wrPtr_q  <= wrPtr_d;
            count_q  <= count_d;
            wrEn_q   <= wrEn_d;
            wrAddr_q <= wrAddr_d;
            wrVal_q  <= wrVal_d;
        end
    end

    // FIFO payload storage; validity is tracked by vld_q, so the data needs no reset.
    always_ff @(posedge clock_i) begin
        if (push) begin
            fifoAddr_q[wrPtr_q] <= wb.wbAddrB_i;
            fifoVal_q[wrPtr_q]  <= wb.wbValB_i;
        end
    end

    assign wb.wbBReady_o  = ready;
    assign wb.regWrEn_o   = wrEn_q;
    assign wb.regWrAddr_o = wrAddr_q;
    assign wb.regWrVal_o  = wrVal_q;
    assign wb.bCount_o    = count_q;
endmodule

// File: tb/tb_pa_wb_arbiter.sv
// tb_pa_wb_arbiter: directed bench for pa_wb_arbiter with a queue-based reference
// model checked every cycle, plus hand-computed literal expectations per scenario.
module tb_pa_wb_arbiter;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 5;
    localparam int B_DEPTH = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    pa_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .B_DEPTH(B_DEPTH)) bus ();

    pa_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .B_DEPTH(B_DEPTH)) dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .wb      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;
        bit                ok;
    } ent_t;

    ent_t              q[$];
    logic              exp_en;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_val;

`ifdef PA_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        bit   acc;
        bit   used;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            exp_en   = 1'b0;
            exp_addr = '0;
            exp_val  = '0;
        end else begin
            acc  = bus.wbB_i && (q.size() != B_DEPTH);
            used = 1'b0;
            exp_en = 1'b0;
            if (bus.wbA_i) begin
                foreach (q[i]) if (q[i].a == bus.wbAddrA_i) q[i].ok = 1'b0;
                exp_en   = 1'b1;
                exp_addr = bus.wbAddrA_i;
                exp_val  = bus.wbValA_i;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                if (e.ok) begin
                    exp_en   = 1'b1;
                    exp_addr = e.a;
                    exp_val  = e.v;
                end
            end else if (BYPASS && acc) begin
                exp_en   = 1'b1;
                exp_addr = bus.wbAddrB_i;
                exp_val  = bus.wbValB_i;
                used     = 1'b1;
            end
            if (acc && !used) begin
                e.a = bus.wbAddrB_i;
                e.v = bus.wbValB_i;
                e.ok = 1'b1;
                q.push_back(e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("model.en",    32'(bus.regWrEn_o),   32'(exp_en));
        chk("model.addr",  32'(bus.regWrAddr_o), 32'(exp_addr));
        chk("model.val",   32'(bus.regWrVal_o),  32'(exp_val));
        chk("model.ready", 32'(bus.wbBReady_o),  32'(q.size() != B_DEPTH));
        chk("model.count", 32'(bus.bCount_o),    32'(q.size()));
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic a, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] av,
                        input logic b, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bv);
        bus.wbA_i     = a;
        bus.wbAddrA_i = aa;
        bus.wbValA_i  = av;
        bus.wbB_i     = b;
        bus.wbAddrB_i = ba;
        bus.wbValB_i  = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic out(input string name, input logic en, input logic [ADDR_W-1:0] ad,
                       input logic [DATA_W-1:0] v, input int cnt);
        chk({name, ".en"}, 32'(bus.regWrEn_o), 32'(en));
        if (en) begin
            chk({name, ".addr"}, 32'(bus.regWrAddr_o), 32'(ad));
            chk({name, ".val"},  32'(bus.regWrVal_o),  32'(v));
        end
        chk({name, ".count"}, 32'(bus.bCount_o), 32'(cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.wbA_i = 1'b0; bus.wbAddrA_i = '0; bus.wbValA_i = '0;
        bus.wbB_i = 1'b0; bus.wbAddrB_i = '0; bus.wbValB_i = '0;
        #1;
        chk("rst.en",    32'(bus.regWrEn_o),  32'd0);
        chk("rst.ready", 32'(bus.wbBReady_o), 32'd1);
        chk("rst.count", 32'(bus.bCount_o),   32'd0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // A only
        step(1'b1, 5'd5, 16'h1234, 1'b0, '0, '0);
        out("aonly", 1'b1, 5'd5, 16'h1234, 0);
        idle();
        out("aonly.after", 1'b0, '0, '0, 0);
        chk("aonly.hold", 32'(bus.regWrAddr_o), 32'd5);

        // collision: A r3 and B r4 together
        step(1'b1, 5'd3, 16'hAAAA, 1'b1, 5'd4, 16'hBBBB);
        out("coll.a", 1'b1, 5'd3, 16'hAAAA, 1);
        idle();
        out("coll.b", 1'b1, 5'd4, 16'hBBBB, 0);
        idle();
        out("coll.end", 1'b0, '0, '0, 0);

        // full: A busy every cycle, five B offers
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd20, 16'(i), 1'b1, 5'(10 + i), 16'(16'h0100 + i));
        chk("full.ready", 32'(bus.wbBReady_o), 32'd0);
        chk("full.count", 32'(bus.bCount_o),   32'd4);
        step(1'b1, 5'd20, 16'h0009, 1'b1, 5'd14, 16'h0104);
        chk("full.5th.count", 32'(bus.bCount_o),   32'd4);
        chk("full.5th.ready", 32'(bus.wbBReady_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle();
            out("full.drain", 1'b1, 5'(10 + i), 16'(16'h0100 + i), 3 - i);
            chk("full.drain.ready", 32'(bus.wbBReady_o), 32'd1);
        end
        idle();
        out("full.end", 1'b0, '0, '0, 0);

        // squash: B r7 queued, then younger A r7
        step(1'b0, '0, '0, 1'b1, 5'd7, 16'h0001);
`ifdef PA_WB_BYPASS_EN
        out("sq.b", 1'b1, 5'd7, 16'h0001, 0);
`else
        out("sq.b", 1'b0, '0, '0, 1);
        step(1'b1, 5'd7, 16'h0002, 1'b0, '0, '0);
        out("sq.a", 1'b1, 5'd7, 16'h0002, 1);
        idle();
        out("sq.silent", 1'b0, '0, '0, 0);
`endif
        idle();
        out("sq.end", 1'b0, '0, '0, 0);
        chk("sq.hold.val", 32'(bus.regWrVal_o), 32'h0002 - 32'(BYPASS));

        // idle B r9: bypass vs FIFO path
        step(1'b0, '0, '0, 1'b1, 5'd9, 16'h00FF);
`ifdef PA_WB_BYPASS_EN
        out("byp", 1'b1, 5'd9, 16'h00FF, 0);
`else
        out("byp.q", 1'b0, '0, '0, 1);
        idle();
        out("byp.w", 1'b1, 5'd9, 16'h00FF, 0);
`endif
        idle();

        // same-cycle A and B to the same register: B is younger and survives
        step(1'b1, 5'd6, 16'h0A0A, 1'b1, 5'd6, 16'h0B0B);
        out("same.a", 1'b1, 5'd6, 16'h0A0A, 1);
        idle();
        out("same.b", 1'b1, 5'd6, 16'h0B0B, 0);
        idle();

        // reset mid-burst with 3 entries queued
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd21, 16'(i), 1'b1, 5'(1 + i), 16'(16'h0200 + i));
        chk("rstm.pre.count", 32'(bus.bCount_o), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstm.count", 32'(bus.bCount_o),   32'd0);
        chk("rstm.en",    32'(bus.regWrEn_o),  32'd0);
        chk("rstm.ready", 32'(bus.wbBReady_o), 32'd1);
        step(1'b0, '0, '0, 1'b0, '0, '0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            out("rstm.nostale", 1'b0, '0, '0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
